hc595_shift_driver: RTL and testbench

- Serial output stage between the 7-segment digit multiplexer and the external 74HC595-style shift/latch register chain.
- Accepts one parallel word per transfer: an 8-bit segment pattern plus an 8-bit digit select.
- Shifts the word out on a divided serial clock, then pulses the storage-register latch.
- Replaces ad-hoc per-cycle shifting with a handshake-driven, timing-controlled serializer.

---
 rtl/seg_drv_pkg.sv | 26 ++
 rtl/half_period_timer.sv | 34 +++
 rtl/hc595_shift_driver.sv | 149 ++++++++++++++
 tb/tb_hc595_shift_driver.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_drv_pkg.sv
// Shared types and constants for the 7-segment serial output path.
// The word layout puts the segment pattern in the high byte and the digit select in the low byte.
package seg_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  localparam int SEG_WORD_WIDTH   = 16;
  localparam int SEG_CLK_DIV      = 4;
  localparam int SEG_LATCH_CYCLES = 2;

  localparam int SEG_PATTERN_MSB  = 15;
  localparam int SEG_PATTERN_LSB  = 8;
  localparam int SEG_DIGIT_MSB    = 7;
  localparam int SEG_DIGIT_LSB    = 0;

  // A counter that must hold the values 0..limit-1 needs at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/half_period_timer.sv
// Loadable down-counter that raises done for exactly one cycle when the loaded interval expires.
// Loading N-1 gives an interval of N cycles, with done high in the last of them.
module half_period_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_reg;
  logic         run_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (load) begin
      cnt_reg <= load_val;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      if (cnt_reg == '0) begin
        run_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign done = run_reg && (cnt_reg == '0);

endmodule

// File: rtl/hc595_shift_driver.sv
// Serializes one parallel word into a 74HC595 chain: WIDTH bits on a divided sclk, then an rclk latch pulse.
// Every output is a flop, so nothing upstream can glitch the external shift/latch pins.
module hc595_shift_driver
  import seg_drv_pkg::*;
#(
  parameter int WIDTH        = SEG_WORD_WIDTH,
  parameter int CLK_DIV      = SEG_CLK_DIV,
  parameter int MSB_FIRST    = 1,
  parameter int LATCH_CYCLES = SEG_LATCH_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             busy,
  output logic             sclk,
  output logic             sdata,
  output logic             rclk
);

  localparam int DIV_W   = cnt_width(CLK_DIV);
  localparam int LAT_W   = cnt_width(LATCH_CYCLES);
  localparam int TW      = (DIV_W > LAT_W) ? DIV_W : LAT_W;
  localparam int BW      = cnt_width(WIDTH);

  localparam logic [TW-1:0] DIV_LOAD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic             sclk_reg;
  logic             sdata_reg;
  logic             rclk_reg;
  logic             ready_reg;
  logic             busy_reg;

  logic             timer_load;
  logic [TW-1:0]    timer_val;
  logic             timer_done;
  logic             accept;
  logic             first_bit;
  logic             shifted_bit;
  logic [WIDTH-1:0] shreg_next;

  // The bit on sdata is always the one at the "outgoing" end of the shift register.
  assign first_bit   = (MSB_FIRST != 0) ? word_in[WIDTH-1] : word_in[0];
  assign shreg_next  = (MSB_FIRST != 0) ? {shreg_reg[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_reg[WIDTH-1:1]};
  assign shifted_bit = (MSB_FIRST != 0) ? shreg_reg[WIDTH-2] : shreg_reg[1];

  assign accept = (state_reg == IDLE) && word_valid && ready_reg;

  // One timer serves both phases of sclk and the latch pulse; it is reloaded on every state change.
  always_comb begin
    timer_load = 1'b0;
    timer_val  = DIV_LOAD;
    case (state_reg)
      IDLE:     timer_load = accept;
      SHIFT_LO: timer_load = timer_done;
      SHIFT_HI: begin
        timer_load = timer_done;
        if (bit_cnt_reg == LAST_BIT) begin
          timer_val = LATCH_LOAD;
        end
      end
      default:  timer_load = 1'b0;
    endcase
  end

  half_period_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      sdata_reg   <= 1'b0;
      rclk_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          sclk_reg  <= 1'b0;
          rclk_reg  <= 1'b0;
          if (accept) begin
            shreg_reg   <= word_in;
            bit_cnt_reg <= '0;
            sdata_reg   <= first_bit;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT_LO;
          end else begin
            sdata_reg   <= 1'b0;
          end
        end
        SHIFT_LO: begin
          if (timer_done) begin
            sclk_reg  <= 1'b1;
            state_reg <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (timer_done) begin
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == LAST_BIT) begin
              rclk_reg  <= 1'b1;
              state_reg <= LATCH;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              shreg_reg   <= shreg_next;
              sdata_reg   <= shifted_bit;
              state_reg   <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (timer_done) begin
            rclk_reg  <= 1'b0;
            sdata_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign word_ready = ready_reg;
  assign busy       = busy_reg;
  assign sclk       = sclk_reg;
  assign sdata      = sdata_reg;
  assign rclk       = rclk_reg;

endmodule

// File: tb/tb_hc595_shift_driver.sv
// Bench for hc595_shift_driver: three instances (defaults, CLK_DIV=1, CLK_DIV=1 LSB-first),
// one of them selected at a time and watched by a waveform monitor fed from an expected-bit queue.
module tb_hc595_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] word_v  [3];
  logic        valid_v [3];
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        sclk_v  [3];
  logic        sdata_v [3];
  logic        rclk_v  [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      hc595_shift_driver #(
        .WIDTH        (16),
        .CLK_DIV      ((gi == 0) ? 4 : 1),
        .MSB_FIRST    ((gi == 2) ? 0 : 1),
        .LATCH_CYCLES (2)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_v[gi]),
        .word_valid (valid_v[gi]),
        .word_ready (ready_v[gi]),
        .busy       (busy_v[gi]),
        .sclk       (sclk_v[gi]),
        .sdata      (sdata_v[gi]),
        .rclk       (rclk_v[gi])
      );
    end
  endgenerate

  int   vectors = 0;
  int   errors  = 0;
  int   sel     = 0;
  bit   mon_en  = 1'b0;
  logic exp_q [$];

  // monitor state
  logic prev_s, prev_d, prev_r, prev_rd;
  int   sd_stable, since_rise, hi_run, lo_run, rclk_run, rdy_lo, rdy_hi_run, last_hi;
  bit   rise_seen, lo_from_fall, rd_track;
  int   edges = 0, pulses = 0, rdy_rises = 0;

  function automatic int cdiv(input int s);
    return (s == 0) ? 4 : 1;
  endfunction

  function automatic int busy_len(input int s);
    return 2 * cdiv(s) * 16 + 2;
  endfunction

  task automatic reset_mon();
    prev_s = 1'b0; prev_d = 1'b0; prev_r = 1'b0; prev_rd = 1'b1;
    sd_stable = 100; since_rise = 0; hi_run = 0; lo_run = 0; rclk_run = 0;
    rdy_lo = 0; rdy_hi_run = 100; last_hi = 100;
    rise_seen = 1'b0; lo_from_fall = 1'b0; rd_track = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    logic s, d, r, rd, b, eb;
    if (mon_en) begin
      if (rst) begin
        reset_mon();
        exp_q.delete();
      end else begin
        s = sclk_v[sel]; d = sdata_v[sel]; r = rclk_v[sel]; rd = ready_v[sel]; b = busy_v[sel];
        vectors++;
        if (b !== ~rd) begin
          errors++; $display("FAIL busy_vs_ready: busy=%b word_ready=%b", b, rd);
        end
        since_rise++;
        if (r === 1'b1) begin
          vectors++;
          if (s !== 1'b0) begin
            errors++; $display("FAIL rclk_overlap: sclk=%b while rclk high, required 0", s);
          end
        end
        if (d !== prev_d) begin
          if (rise_seen) begin
            vectors++;
            if (since_rise < cdiv(sel)) begin
              errors++; $display("FAIL sdata_hold: %0d cycles after sclk rise, required >= %0d", since_rise, cdiv(sel));
            end
          end
          sd_stable = 0;
        end else begin
          sd_stable++;
        end
        if (s === 1'b1 && prev_s === 1'b0) begin
          vectors++;
          if (sd_stable < cdiv(sel)) begin
            errors++; $display("FAIL sdata_setup: stable %0d cycles, required >= %0d", sd_stable, cdiv(sel));
          end
          vectors++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_sclk: got a rising edge, required none (queue empty)");
          end else begin
            eb = exp_q.pop_front();
            if (d !== eb) begin
              errors++; $display("FAIL sdata_bit: edge %0d got %b, required %b", edges, d, eb);
            end
          end
          if (lo_from_fall) begin
            vectors++;
            if (lo_run != cdiv(sel)) begin
              errors++; $display("FAIL sclk_low_width: got %0d cycles, required %0d", lo_run, cdiv(sel));
            end
          end
          hi_run = 1; since_rise = 0; rise_seen = 1'b1; edges++;
        end else if (s === 1'b0 && prev_s === 1'b1) begin
          vectors++;
          if (hi_run != cdiv(sel)) begin
            errors++; $display("FAIL sclk_high_width: got %0d cycles, required %0d", hi_run, cdiv(sel));
          end
          lo_run = 1; lo_from_fall = 1'b1;
        end else if (s === 1'b1) begin
          hi_run++;
        end else begin
          lo_run++;
        end
        if (r === 1'b1 && prev_r === 1'b0) begin
          rclk_run = 1; lo_from_fall = 1'b0;
        end else if (r === 1'b0 && prev_r === 1'b1) begin
          vectors++;
          if (rclk_run != 2) begin
            errors++; $display("FAIL rclk_width: got %0d cycles, required 2", rclk_run);
          end
          pulses++;
        end else if (r === 1'b1) begin
          rclk_run++;
        end
        if (rd === 1'b0 && prev_rd === 1'b1) begin
          last_hi = rdy_hi_run; rdy_lo = 1; rd_track = 1'b1;
        end else if (rd === 1'b1 && prev_rd === 1'b0) begin
          if (rd_track) begin
            vectors++;
            if (rdy_lo != busy_len(sel)) begin
              errors++; $display("FAIL ready_low_len: got %0d cycles, required %0d", rdy_lo, busy_len(sel));
            end
          end
          rdy_rises++; rdy_hi_run = 1; rd_track = 1'b0;
        end else if (rd === 1'b0) begin
          rdy_lo++;
        end else begin
          rdy_hi_run++;
        end
        prev_s = s; prev_d = d; prev_r = r; prev_rd = rd;
      end
    end
  end

  task automatic push_bits(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back((sel == 2) ? w[i] : w[15 - i]);
    end
  endtask

  task automatic wait_ready(input logic level, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (ready_v[sel] === level) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL %s: word_ready never reached %b within 3000 cycles", name, level);
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    push_bits(w);
    @(posedge clk); #1;
    word_v[sel]  = w;
    valid_v[sel] = 1'b1;
    wait_ready(1'b0, "accept_timeout");
    valid_v[sel] = 1'b0;
  endtask

  task automatic wait_rises(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk); #1;
      if (rdy_rises >= target) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL done_timeout: ready returned %0d times, required %0d", rdy_rises, target);
    end
  endtask

  task automatic run_word(input logic [15:0] w, input string name);
    int be = edges, bp = pulses, br = rdy_rises;
    send_word(w);
    wait_rises(br + 1);
    vectors++;
    if (edges - be != 16) begin
      errors++; $display("FAIL %s_edges: got %0d sclk edges, required 16", name, edges - be);
    end
    vectors++;
    if (pulses - bp != 1) begin
      errors++; $display("FAIL %s_rclk: got %0d rclk pulses, required 1", name, pulses - bp);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s_bits_left: got %0d unshifted bits, required 0", name, exp_q.size());
    end
    $display("%s: word %h sent on instance %0d", name, w, sel);
  endtask

  task automatic check_idle_outputs(input int s, input string name);
    vectors++;
    if (sclk_v[s] !== 1'b0 || sdata_v[s] !== 1'b0 || rclk_v[s] !== 1'b0 ||
        ready_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
      errors++;
      $display("FAIL %s[%0d]: sclk=%b sdata=%b rclk=%b ready=%b busy=%b, required 0 0 0 1 0",
               name, s, sclk_v[s], sdata_v[s], rclk_v[s], ready_v[s], busy_v[s]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      word_v[i] = '0; valid_v[i] = 1'b0;
    end
    #12 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset_async");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    reset_mon();
    mon_en = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check_idle_outputs(i, "reset_release");
    $display("test_reset: done");
  endtask

  task automatic test_bit_order();
    sel = 1;
    run_word(16'hA5C3, "bit_order");
  endtask

  task automatic test_default_timing();
    sel = 0;
    run_word(16'h00FF, "default_timing");
  endtask

  task automatic test_back_to_back();
    int be = edges, bp = pulses, br = rdy_rises;
    sel = 0;
    push_bits(16'h0001);
    push_bits(16'hFFFF);
    @(posedge clk); #1;
    word_v[sel]  = 16'h0001;
    valid_v[sel] = 1'b1;
    wait_ready(1'b0, "b2b_accept1");
    word_v[sel] = 16'hFFFF;
    wait_ready(1'b1, "b2b_ready_return");
    wait_ready(1'b0, "b2b_accept2");
    valid_v[sel] = 1'b0;
    wait_rises(br + 2);
    vectors++;
    if (edges - be != 32) begin
      errors++; $display("FAIL b2b_edges: got %0d, required 32", edges - be);
    end
    vectors++;
    if (pulses - bp != 2) begin
      errors++; $display("FAIL b2b_rclk: got %0d, required 2", pulses - bp);
    end
    vectors++;
    if (last_hi != 1) begin
      errors++; $display("FAIL b2b_gap: word_ready high %0d cycles between words, required 1", last_hi);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_bits_left: got %0d, required 0", exp_q.size());
    end
    $display("test_back_to_back: words 0001 and ffff sent");
  endtask

  task automatic test_reset_mid();
    int be, bp;
    bit ok = 1'b0;
    sel = 0;
    be = edges;
    send_word(16'hFFFF);
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk); #1;
      if (edges - be >= 5) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      errors++; $display("FAIL mid_edges_timeout: got %0d edges, required 5", edges - be);
    end
    vectors++;
    if (sclk_v[sel] !== 1'b1) begin
      errors++; $display("FAIL mid_pre_sclk: got %b, required 1", sclk_v[sel]);
    end
    #1 rst = 1'b1;
    #1 check_idle_outputs(sel, "reset_mid");
    bp = pulses;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    vectors++;
    if (pulses != bp || rclk_v[sel] !== 1'b0) begin
      errors++; $display("FAIL mid_no_latch: got %0d rclk pulses after reset, required 0", pulses - bp);
    end
    run_word(16'h1234, "after_reset");
  endtask

  task automatic test_lsb_first();
    sel = 2;
    run_word(16'h8001, "lsb_first");
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_default_timing();
    test_back_to_back();
    test_reset_mid();
    test_lsb_first();
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
